i_fetch: RTL and testbench
==========================

# i_fetch

Instruction-fetch stage sitting directly upstream of the direct-mapped instruction cache. It owns the PC, drives the cache's processor-side request (address, strobe) and waits on its ready. It captures returned instructions into the IF/ID pipeline register. It handles decode-stage stalls, branch/jump redirects and redirects that arrive while a cache miss is outstanding, without ever changing the cache address mid-miss.

## Interface
- A_WIDTH, 32, address width; matches the cache's address width.
- RESET_PC, 0, PC value after reset; bits [1:0] must be 00.
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- i_a  out  A_WIDTH  fetch address to cache; equals pc.
- i_strobe  out  1  fetch request to cache.
- i_din  in  32  instruction word from cache.
- i_ready  in  1  cache ready; combinational, same cycle on a hit.
- stall  in  1  decode hazard stall; IF/ID must hold.
- redirect  in  1  taken branch/jump from EX; one-cycle pulse.
- redirect_pc  in  A_WIDTH  redirect target; bits [1:0] ignored and forced to 00.
- if_inst  out  32  IF/ID instruction; reset 0 (NOP).
- if_pc  out  A_WIDTH  IF/ID PC of if_inst; reset 0.
- if_pc4  out  A_WIDTH  if_pc+4, modulo 2^A_WIDTH; reset 4.
- if_valid  out  1  IF/ID holds a real instruction; reset 0.
- fetch_busy  out  1  state==MISS.
- miss_cycles  out  16  count of cycles spent in MISS; saturates at 0xFFFF; reset 0.

## Operation
- Registers:
  - pc, reset RESET_PC.
  - state ∈ {RUN, MISS, HOLD}, reset RUN.
  - hold_inst and hold_pc form the hold buffer.
  - squash flag and redir_tgt hold a pending redirect; reset 0.
- i_a = pc in every state.
- In any state, "load IF/ID" means: if_inst, if_pc and if_valid are written; pc advances to pc+4 (wraps to 0 from the top of the address space).
- RUN:
  - i_strobe = ~stall & ~redirect.
  - redirect: pc <= redirect_pc. if_valid <= 0. Redirect wins over stall.
  - Else, stall: no change.
  - Else, i_ready: load IF/ID with {i_din, pc, 1}.
  - Else (miss): go to MISS. if_valid <= 0.
- MISS:
  - i_strobe = 1. i_a stays fixed until i_ready.
  - redirect: squash <= 1. redir_tgt <= redirect_pc. The latest redirect wins. if_valid <= 0 immediately.
  - i_ready with squash (including a redirect in the same cycle): discard i_din. pc <= redir_tgt or the same-cycle redirect_pc. squash <= 0. if_valid <= 0. Go to RUN.
  - i_ready, no squash, stall: capture i_din and pc into the hold buffer. Go to HOLD.
  - i_ready, no squash, no stall: load IF/ID. Go to RUN.
  - No i_ready, no stall: if_valid <= 0 (bubble).
- HOLD:
  - i_strobe = 0.
  - redirect: drop the buffer. pc <= redirect_pc. if_valid <= 0. Go to RUN.
  - Else, ~stall: load IF/ID from the hold buffer. Go to RUN.
- While stall=1 and no redirect, if_inst, if_pc and if_valid hold their values in every state.
- miss_cycles increments on every clock in MISS, up to saturation.

## Timing
- Hit: i_strobe and i_ready in the same cycle; the instruction is in IF/ID at the next edge. Throughput is 1 instruction/cycle.
- Miss of N memory cycles: N bubbles (if_valid=0), then the instruction.
- Redirect in RUN: the target is fetched in the next cycle; 1 bubble on IF/ID.
- Redirect during a miss: the target is fetched in the cycle after the squashed miss completes.
- clrn low at any time:
  - Async clear of all registers.
  - i_strobe goes to 0 while clrn is low; a memory transfer in progress is abandoned.
  - After release, fetch restarts at RESET_PC in RUN.

## Structure
- Shared package holds:
  - the state enum {RUN, MISS, HOLD};
  - NOP constant 32'h0000_0000;
  - default RESET_PC.
- Single module; no sub-module. The hold buffer and IF/ID register are inline registers.

## Test plan
- Reset and sequential hits: RESET_PC=0, cache always hits with i_din=pc → IF/ID shows pc 0, 4, 8 on consecutive cycles; if_valid=1 from cycle 1 onward.
- Miss: 3-cycle miss at pc 0x40 → 3 bubbles; fetch_busy=1 for 3 cycles; i_a stays 0x40; miss_cycles=3; then if_pc=0x40.
- Stall during miss: stall=1 when i_ready arrives → state HOLD, i_strobe=0; stall drops 2 cycles later → if_pc=0x40 next edge, then pc=0x44.
- Redirect mid-miss: redirect to 0x103 during a miss at 0x40 → i_a stays 0x40 until ready; returned word discarded, never if_valid; next fetch at 0x100.
- Simultaneous redirect and stall in RUN: redirect_pc=0x200 → if_valid=0 next edge; i_a=0x200.
- Reset mid-miss: clrn pulsed low → i_strobe=0; after release i_a=RESET_PC, if_valid=0, miss_cycles=0.

Source files
------------

// File: rtl/i_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch state encoding, the NOP word and the default reset PC.
package i_fetch_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/i_fetch.sv
// Instruction fetch: owns the PC, requests the I-cache and fills the IF/ID register.
// Latency: a hit lands in IF/ID at the next edge; a miss adds one bubble per memory cycle.
// Backpressure: stall holds IF/ID; a word returned under stall parks in the hold buffer.
module i_fetch
    import i_fetch_pkg::*;
#(
    parameter int                 A_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               clrn,
    output logic [A_WIDTH-1:0] i_a,
    output logic               i_strobe,
    input  logic [31:0]        i_din,
    input  logic               i_ready,
    input  logic               stall,
    input  logic               redirect,
    input  logic [A_WIDTH-1:0] redirect_pc,
    output logic [31:0]        if_inst,
    output logic [A_WIDTH-1:0] if_pc,
    output logic [A_WIDTH-1:0] if_pc4,
    output logic               if_valid,
    output logic               fetch_busy,
    output logic [15:0]        miss_cycles
);

    fetch_state_t       state, state_nxt;
    logic [A_WIDTH-1:0] pc, pc_nxt, pc_inc, rp;
    logic [31:0]        hold_inst, hold_inst_nxt;
    logic [A_WIDTH-1:0] hold_pc, hold_pc_nxt;
    logic               squash, squash_nxt;
    logic [A_WIDTH-1:0] redir_tgt, redir_tgt_nxt;
    logic [31:0]        if_inst_nxt;
    logic [A_WIDTH-1:0] if_pc_nxt;
    logic               if_valid_nxt;
    logic               strobe_c, load_fetch, load_hold;

    assign rp         = redirect_pc & ~A_WIDTH'(3);
    assign pc_inc     = pc + A_WIDTH'(4);
    assign i_a        = pc;
    assign if_pc4     = if_pc + A_WIDTH'(4);
    assign fetch_busy = (state == MISS);
    // The request must drop while reset is held so the cache abandons any transfer.
    assign i_strobe   = clrn & strobe_c;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        hold_inst_nxt = hold_inst;
        hold_pc_nxt   = hold_pc;
        squash_nxt    = squash;
        redir_tgt_nxt = redir_tgt;
        if_inst_nxt   = if_inst;
        if_pc_nxt     = if_pc;
        if_valid_nxt  = if_valid;
        strobe_c      = 1'b0;
        load_fetch    = 1'b0;
        load_hold     = 1'b0;
        case (state)
            RUN: begin
                strobe_c = ~stall & ~redirect;
                if (redirect) begin
                    pc_nxt       = rp;
                    if_valid_nxt = 1'b0;
                end else if (!stall) begin
                    if (i_ready) begin
                        load_fetch = 1'b1;
                    end else begin
                        state_nxt    = MISS;
                        if_valid_nxt = 1'b0;
                    end
                end
            end
            MISS: begin
                // pc is frozen here; a redirect only retargets the fetch after the miss ends.
                strobe_c = 1'b1;
                if (i_ready && (squash || redirect)) begin
                    pc_nxt       = redirect ? rp : redir_tgt;
                    squash_nxt   = 1'b0;
                    if_valid_nxt = 1'b0;
                    state_nxt    = RUN;
                end else if (redirect) begin
                    squash_nxt    = 1'b1;
                    redir_tgt_nxt = rp;
                    if_valid_nxt  = 1'b0;
                end else if (i_ready && stall) begin
                    hold_inst_nxt = i_din;
                    hold_pc_nxt   = pc;
                    state_nxt     = HOLD;
                end else if (i_ready) begin
                    load_fetch = 1'b1;
                    state_nxt  = RUN;
                end else if (!stall) begin
                    if_valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt       = rp;
                    if_valid_nxt = 1'b0;
                    state_nxt    = RUN;
                end else if (!stall) begin
                    load_hold = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (load_fetch) begin
            if_inst_nxt  = i_din;
            if_pc_nxt    = pc;
            if_valid_nxt = 1'b1;
            pc_nxt       = pc_inc;
        end
        if (load_hold) begin
            if_inst_nxt  = hold_inst;
            if_pc_nxt    = hold_pc;
            if_valid_nxt = 1'b1;
            pc_nxt       = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= RUN;
            pc          <= RESET_PC;
            hold_inst   <= NOP;
            hold_pc     <= '0;
            squash      <= 1'b0;
            redir_tgt   <= '0;
            if_inst     <= NOP;
            if_pc       <= '0;
            if_valid    <= 1'b0;
            miss_cycles <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            hold_inst <= hold_inst_nxt;
            hold_pc   <= hold_pc_nxt;
            squash    <= squash_nxt;
            redir_tgt <= redir_tgt_nxt;
            if_inst   <= if_inst_nxt;
            if_pc     <= if_pc_nxt;
            if_valid  <= if_valid_nxt;
            if (state == MISS && miss_cycles != 16'hFFFF)
                miss_cycles <= miss_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_i_fetch.sv
// Scoreboarded bench for i_fetch: expected IF/ID PCs are queued by the stimulus,
// a negedge monitor pops one per newly loaded instruction; control outputs are checked inline.
module tb_i_fetch;
    import i_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] i_a;
    logic        i_strobe;
    logic [31:0] i_din;
    logic        i_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        fetch_busy;
    logic [15:0] miss_cycles;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    i_fetch #(.A_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .clrn(clrn), .i_a(i_a), .i_strobe(i_strobe), .i_din(i_din),
        .i_ready(i_ready), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4), .if_valid(if_valid),
        .fetch_busy(fetch_busy), .miss_cycles(miss_cycles)
    );

    always #5 clk = ~clk;

    // The cache returns the fetch address as the instruction word.
    assign i_din = i_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one pop per newly loaded IF/ID entry (a held entry is not re-checked).
    initial begin
        logic        prev_valid;
        logic [31:0] last_pc;
        logic [31:0] exp_pc;
        prev_valid = 1'b0;
        last_pc    = '0;
        forever begin
            @(negedge clk);
            if (if_valid === 1'b1 && !(prev_valid && if_pc == last_pc)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h with queue empty at %0t", if_pc, $time);
                end else begin
                    exp_pc = exp_q.pop_front();
                    chk("if_pc", if_pc, exp_pc);
                    chk("if_inst", if_inst, exp_pc);
                end
            end
            prev_valid = (if_valid === 1'b1);
            last_pc    = if_pc;
        end
    end

    initial begin
        clrn = 1'b0; i_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1;
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc4", if_pc4, 32'h4);
        chk("rst_if_inst", if_inst, NOP);
        chk("rst_miss_cycles", {16'b0, miss_cycles}, 32'd0);
        chk("rst_strobe", {31'b0, i_strobe}, 32'd0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;

        // Sequential hits 0x00..0x3C
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(32'(4 * i));
            @(negedge clk);
        end
        chk("seq_i_a", i_a, 32'h40);

        // 3-cycle miss at 0x40
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("miss_busy", {31'b0, fetch_busy}, 32'd1);
            chk("miss_i_a", i_a, 32'h40);
            chk("miss_bubble", {31'b0, if_valid}, 32'd0);
            chk("miss_strobe", {31'b0, i_strobe}, 32'd1);
        end
        i_ready = 1'b1;
        exp_q.push_back(32'h40);
        @(negedge clk);
        chk("miss_done_busy", {31'b0, fetch_busy}, 32'd0);
        chk("miss_cycles_3", {16'b0, miss_cycles}, 32'd3);

        // Miss at 0x44 completing under stall -> HOLD
        i_ready = 1'b0;
        @(negedge clk);
        i_ready = 1'b1; stall = 1'b1;
        @(negedge clk);
        chk("hold_strobe", {31'b0, i_strobe}, 32'd0);
        chk("hold_busy", {31'b0, fetch_busy}, 32'd0);
        chk("hold_valid", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        chk("hold_i_a", i_a, 32'h44);
        stall = 1'b0;
        exp_q.push_back(32'h44);
        @(negedge clk);
        chk("hold_next_i_a", i_a, 32'h48);
        chk("miss_cycles_4", {16'b0, miss_cycles}, 32'd4);
        exp_q.push_back(32'h48);
        @(negedge clk);

        // Redirect to 0x103 while missing at 0x4C
        i_ready = 1'b0;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 1'b0;
        chk("sq_i_a_0", i_a, 32'h4C);
        @(negedge clk);
        chk("sq_i_a_1", i_a, 32'h4C);
        i_ready = 1'b1;
        @(negedge clk);
        chk("sq_target", i_a, 32'h100);
        chk("sq_valid", {31'b0, if_valid}, 32'd0);
        chk("miss_cycles_7", {16'b0, miss_cycles}, 32'd7);
        exp_q.push_back(32'h100);
        @(negedge clk);

        // Redirect together with stall in RUN
        redirect = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
        #1;
        chk("rs_strobe", {31'b0, i_strobe}, 32'd0);
        @(negedge clk);
        redirect = 1'b0; stall = 1'b0;
        chk("rs_valid", {31'b0, if_valid}, 32'd0);
        chk("rs_i_a", i_a, 32'h200);
        exp_q.push_back(32'h200);
        @(negedge clk);

        // Plain stall in RUN holds IF/ID
        stall = 1'b1;
        repeat (2) @(negedge clk);
        chk("stall_hold_pc", if_pc, 32'h200);
        chk("stall_hold_valid", {31'b0, if_valid}, 32'd1);
        stall = 1'b0;
        exp_q.push_back(32'h204);
        @(negedge clk);

        // Reset in the middle of a miss at 0x208
        i_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", {31'b0, fetch_busy}, 32'd1);
        clrn = 1'b0;
        #1;
        chk("rst_mid_strobe", {31'b0, i_strobe}, 32'd0);
        chk("rst_mid_busy", {31'b0, fetch_busy}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        chk("post_rst_i_a", i_a, 32'h0);
        chk("post_rst_valid", {31'b0, if_valid}, 32'd0);
        chk("post_rst_miss_cycles", {16'b0, miss_cycles}, 32'd0);
        i_ready = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);

        // PC wrap at the top of the address space; low target bits are ignored
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0;
        chk("wrap_i_a", i_a, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_pc4", if_pc4, 32'h0);
        chk("wrap_next_i_a", i_a, 32'h0);

        stall = 1'b1;
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
